// File: rtl/hack_run_ctl_if.sv
// ---------------------------------------------------------------------------
// hack_run_ctl_if
// Signal bundle between the run/debug controller and its surroundings
// (top level, debug UART bridge and the Hack cpu).
//
// Handshake semantics: every *_req / *_reset / clr_cnt / wdt_kick signal is a
// one-cycle pulse sampled on the rising clock edge; dbg_req is a level that
// the debug master holds for as long as it wants the memory port, and it may
// only touch memory while dbg_gnt is high.
//
// Modports:
//   slave  - the controller (requests in, cpu control and status out)
//   master - the requester side (requests out, cpu control and status in)
// ---------------------------------------------------------------------------
interface hack_run_ctl_if #(
  parameter int CNT_W = 32
) ();
  logic             soft_reset;
  logic             run_req;
  logic             halt_req;
  logic             step_req;
  logic             bp_en;
  logic [15:0]      bp_addr;
  logic [15:0]      pc;
  logic             clr_cnt;
  logic             dbg_req;
  logic             wdt_kick;
  logic             cpu_reset;
  logic             cpu_en;
  logic             dbg_gnt;
  logic             mem_sel;
  logic             halted;
  logic [2:0]       halt_cause;
  logic [CNT_W-1:0] cycle_cnt;

  modport slave (
    input  soft_reset, run_req, halt_req, step_req, bp_en, bp_addr, pc,
           clr_cnt, dbg_req, wdt_kick,
    output cpu_reset, cpu_en, dbg_gnt, mem_sel, halted, halt_cause, cycle_cnt
  );

  modport master (
    output soft_reset, run_req, halt_req, step_req, bp_en, bp_addr, pc,
           clr_cnt, dbg_req, wdt_kick,
    input  cpu_reset, cpu_en, dbg_gnt, mem_sel, halted, halt_cause, cycle_cnt
  );
endinterface

// File: rtl/hack_run_ctl.sv
// ---------------------------------------------------------------------------
// hack_run_ctl
// Run/debug controller for the Hack cpu core. Sequences the core reset,
// gates execution through cpu_en, halts on request or on a PC breakpoint,
// single-steps, and hands the data-memory port to a debug master while the
// core is halted.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   bus         hack_run_ctl_if.slave (requests, breakpoint, pc in;
//               cpu_reset, cpu_en, dbg_gnt, mem_sel, halted, halt_cause,
//               cycle_cnt out)
//   o_dbg_state current FSM state (0 BOOT, 1 RUN, 2 HALT, 3 STEP)
//
// Optional feature macro: HACK_RUN_CTL_WDT_EN
//   Defined   - a watchdog counts RUN cycles and halts the core with cause 4
//               after WDT_LIMIT cycles without a wdt_kick.
//   Undefined - no watchdog; wdt_kick is ignored.
// ---------------------------------------------------------------------------
module hack_run_ctl #(
  parameter int RST_CYCLES = 4,
  parameter int AUTORUN    = 1,
  parameter int CNT_W      = 32,
  parameter int WDT_LIMIT  = 65535
) (
  input  logic                clk,
  input  logic                reset_n,
  hack_run_ctl_if.slave       bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  localparam int          BOOT_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_RELOAD = BOOT_W'(RST_CYCLES - 1);

  localparam logic [2:0] CAUSE_BOOT = 3'd0;
  localparam logic [2:0] CAUSE_HREQ = 3'd1;
  localparam logic [2:0] CAUSE_BP   = 3'd2;
  localparam logic [2:0] CAUSE_STEP = 3'd3;
  localparam logic [2:0] CAUSE_WDT  = 3'd4;

  state_t             r_state;
  logic [BOOT_W-1:0]  r_boot_cnt;
  logic               r_cpu_reset;
  logic               r_halted;
  logic               r_dbg_gnt;
  logic               r_mem_sel;
  logic [2:0]         r_cause;
  logic [CNT_W-1:0]   r_cycle_cnt;
  logic               r_bp_skip;

  state_t             w_next_state;
  logic [2:0]         w_next_cause;
  logic               w_bp_hit;
  logic               w_cpu_en;
  logic               w_wdt_exp;

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
`ifdef HACK_RUN_CTL_WDT_EN
  localparam int WDT_W = $clog2(WDT_LIMIT + 1);

  logic [WDT_W-1:0] r_wdt;

  // Held at zero outside RUN, so every entry into RUN starts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdt <= '0;
    end else if (r_state != ST_RUN || bus.wdt_kick) begin
      r_wdt <= '0;
    end else begin
      r_wdt <= r_wdt + 1'b1;
    end
  end

  // Last allowed RUN cycle; a kick in that same cycle still rescues it.
  assign w_wdt_exp = (r_state == ST_RUN) &&
                     (r_wdt == WDT_W'(WDT_LIMIT - 1)) && !bus.wdt_kick;
`else
  localparam int LP_UNUSED_WDT_LIMIT = WDT_LIMIT;
  logic w_unused_wdt_kick;
  assign w_unused_wdt_kick = bus.wdt_kick;
  assign w_wdt_exp         = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Breakpoint and execute enable
  // -------------------------------------------------------------------------
  // bp_skip lets a resume from HALT execute the instruction sitting at the
  // breakpoint address instead of re-hitting it immediately.
  assign w_bp_hit = bus.bp_en && (bus.pc == bus.bp_addr) && !r_bp_skip;

  always_comb begin
    w_cpu_en = 1'b0;
    case (r_state)
      ST_BOOT: w_cpu_en = 1'b1;          // cpu must sample its sync reset
      ST_RUN:  w_cpu_en = !w_bp_hit;     // breakpoint suppresses this insn
      ST_HALT: w_cpu_en = 1'b0;
      ST_STEP: w_cpu_en = 1'b1;          // breakpoints ignored while stepping
      default: w_cpu_en = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_next_cause = r_cause;
    if (bus.soft_reset) begin
      w_next_state = ST_BOOT;
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (r_boot_cnt == '0) begin
            if (AUTORUN != 0) begin
              w_next_state = ST_RUN;
            end else begin
              w_next_state = ST_HALT;
              w_next_cause = CAUSE_BOOT;
            end
          end
        end
        ST_RUN: begin
          // Priority: breakpoint, then halt_req, then watchdog.
          if (w_bp_hit) begin
            w_next_state = ST_HALT;
            w_next_cause = CAUSE_BP;
          end else if (bus.halt_req) begin
            w_next_state = ST_HALT;
            w_next_cause = CAUSE_HREQ;
          end else if (w_wdt_exp) begin
            w_next_state = ST_HALT;
            w_next_cause = CAUSE_WDT;
          end
        end
        ST_HALT: begin
          // The core stays parked while the debug master owns memory.
          if (!r_dbg_gnt) begin
            if (bus.run_req) begin
              w_next_state = ST_RUN;
            end else if (bus.step_req) begin
              w_next_state = ST_STEP;
            end
          end
        end
        ST_STEP: begin
          w_next_state = ST_HALT;
          w_next_cause = CAUSE_STEP;
        end
        default: begin
          w_next_state = ST_BOOT;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_BOOT;
      r_boot_cnt  <= BOOT_RELOAD;
      r_cpu_reset <= 1'b1;
      r_halted    <= 1'b0;
      r_dbg_gnt   <= 1'b0;
      r_mem_sel   <= 1'b0;
      r_cause     <= CAUSE_BOOT;
      r_cycle_cnt <= '0;
      r_bp_skip   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cpu_reset <= (w_next_state == ST_BOOT);
      r_halted    <= (w_next_state == ST_HALT);
      r_cause     <= w_next_cause;

      if (bus.soft_reset) begin
        r_boot_cnt <= BOOT_RELOAD;
      end else if (r_state == ST_BOOT && r_boot_cnt != '0) begin
        r_boot_cnt <= r_boot_cnt - 1'b1;
      end

      // Grant only while the core is and stays halted, so it can never
      // overlap an enabled cpu cycle. soft_reset leaves HALT and so drops it.
      r_dbg_gnt <= (r_state == ST_HALT) && (w_next_state == ST_HALT) &&
                   bus.dbg_req;
      r_mem_sel <= (r_state == ST_HALT) && (w_next_state == ST_HALT) &&
                   bus.dbg_req;

      // Armed for exactly the first RUN cycle after a resume.
      r_bp_skip <= (r_state == ST_HALT) && (w_next_state == ST_RUN);

      if (bus.clr_cnt) begin
        r_cycle_cnt <= '0;
      end else if (w_cpu_en && r_state != ST_BOOT && r_cycle_cnt != '1) begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
    end
  end

  assign bus.cpu_reset  = r_cpu_reset;
  assign bus.cpu_en     = w_cpu_en;
  assign bus.dbg_gnt    = r_dbg_gnt;
  assign bus.mem_sel    = r_mem_sel;
  assign bus.halted     = r_halted;
  assign bus.halt_cause = r_cause;
  assign bus.cycle_cnt  = r_cycle_cnt;
  assign o_dbg_state    = r_state;

endmodule

// File: doc/hack_run_ctl.md
Name: hack_run_ctl

Overview:
- Run/debug controller for the Hack CPU core.
- Sequences the core's reset, gates its execution with a clock enable, halts on request or on a PC breakpoint, and single-steps.
- Arbitrates the data-memory port between the CPU and a debug master, which may access memory only while the core is halted.
- Sits between the top level / debug UART bridge and the cpu instance; the cpu gains a `cpu_en` input (A/D/pc update only when high).

Parameters:
- RST_CYCLES, 4: number of cycles `cpu_reset` is held in BOOT (>=1).
- AUTORUN, 1: 1 = go BOOT->RUN; 0 = go BOOT->HALT.
- CNT_W, 32: width of the executed-instruction counter.
- WDT_LIMIT, 65535: watchdog limit in RUN cycles (only with the optional feature).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- soft_reset  in  1  pulse; restart the BOOT sequence
- run_req  in  1  pulse; resume from HALT
- halt_req  in  1  pulse; stop execution
- step_req  in  1  pulse; execute one instruction from HALT
- bp_en  in  1  breakpoint enable
- bp_addr  in  16  breakpoint PC
- pc  in  16  cpu pc output
- clr_cnt  in  1  pulse; clear cycle_cnt
- dbg_req  in  1  debug master requests the memory port (level)
- wdt_kick  in  1  pulse; restart the watchdog (optional feature)
- cpu_reset  out  1  drives cpu reset
- cpu_en  out  1  cpu execute enable
- dbg_gnt  out  1  debug master owns the memory port
- mem_sel  out  1  memory mux select: 0 = CPU, 1 = debug
- halted  out  1  state == HALT
- halt_cause  out  3  0 boot, 1 halt_req, 2 breakpoint, 3 step done, 4 watchdog
- cycle_cnt  out  CNT_W  executed instructions

Behaviour:
- **Reset.** `reset_n` low (async) forces:
  - state = BOOT, boot counter = RST_CYCLES-1;
  - cpu_reset = 1, cpu_en = 1, dbg_gnt = 0, mem_sel = 0, halt_cause = 0, cycle_cnt = 0, bp_skip = 0.
- **States.** BOOT, RUN, HALT, STEP. All state is registered. `cpu_en` is combinational from the state and the breakpoint hit.
- **BOOT.**
  - cpu_reset = 1 and cpu_en = 1 so the cpu samples its synchronous reset.
  - The counter decrements each cycle. At 0 the next state is RUN (AUTORUN = 1) or HALT (AUTORUN = 0, cause 0).
  - Request pulses are ignored.
- **RUN.**
  - cpu_en = ~bp_hit, where bp_hit = bp_en & (pc == bp_addr) & ~bp_skip.
  - On bp_hit: cpu_en is low in that same cycle, so the instruction at bp_addr is not executed. Next state HALT, cause 2.
  - On halt_req: the current instruction executes. Next state HALT, cause 1.
  - If halt_req and bp_hit coincide, cause 2 wins.
  - bp_skip is set on entry to RUN from HALT and cleared after the first RUN cycle. This lets a resume proceed past a breakpoint at the current pc.
- **HALT.**
  - cpu_en = 0.
  - run_req takes priority over step_req. run_req -> RUN; step_req -> STEP.
  - halt_req is ignored.
  - While dbg_gnt = 1, run_req and step_req are ignored.
- **STEP.**
  - cpu_en = 1 for exactly one cycle; breakpoints are ignored.
  - Next state HALT, cause 3.
- **soft_reset.** In any state, the next state is BOOT with the counter reloaded; dbg_gnt drops in the same edge. It has priority over all other requests.
- **Debug arbitration.**
  - dbg_gnt rises on the edge after dbg_req = 1 while state == HALT.
  - dbg_gnt falls on the edge after dbg_req = 0, or on soft_reset.
  - mem_sel = dbg_gnt (registered).
  - The grant never coexists with cpu_en = 1.
- **cycle_cnt.**
  - Increments on each edge where cpu_en = 1 and state != BOOT.
  - Saturates at all-ones.
  - clr_cnt clears it; clear wins over increment.

Optional Feature:
- Macro: HACK_RUN_CTL_WDT_EN.
- **Defined:** a watchdog counter runs only in RUN.
  - It is cleared on entry to RUN and by wdt_kick.
  - Reaching WDT_LIMIT forces the next state HALT, cause 4, with the current instruction still executed.
  - Breakpoint and halt_req take precedence in the same cycle.
- **Undefined:** no watchdog logic; wdt_kick is ignored; cause 4 is never produced.

Test Plan:
- **Reset/boot.** reset_n low then released with RST_CYCLES = 4, AUTORUN = 1 -> cpu_reset = 1 for exactly 4 cycles, then state RUN, cpu_en = 1, cycle_cnt counts from 0.
- **Breakpoint and resume.** bp_en = 1, bp_addr = 0x0010, pc sweeps 0x000E..0x0010 -> cpu_en = 0 in the pc = 0x0010 cycle, halted = 1, cause 2, cycle_cnt = 2 more than at 0x000E. Then run_req -> RUN, pc = 0x0010 executes without re-hit.
- **Single step.** In HALT, step_req pulse -> exactly one cpu_en cycle, halted again, cause 3, cycle_cnt += 1. step_req and run_req together -> RUN.
- **Debug grant.** In HALT, dbg_req = 1 -> dbg_gnt = mem_sel = 1 next cycle; run_req while granted is ignored. dbg_req = 0 -> grant drops; a subsequent run_req resumes.
- **soft_reset.** soft_reset while granted mid-HALT -> dbg_gnt = 0 next edge, BOOT with cpu_reset asserted 4 cycles.
- **Watchdog (HACK_RUN_CTL_WDT_EN, WDT_LIMIT = 8).** Run without wdt_kick -> HALT after 8 RUN cycles, cause 4. With wdt_kick every 5 cycles -> no halt.
